id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-operand forwarding for the 5-stage MIPS core.
//  - Captures decoded operands and control from ID; drives the ALU operand and control inputs.
//  - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  - Detects load-use hazards and inserts a bubble while upstream holds.

---
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-operand forwarding and load-use bubble insertion.
// Optional feature macro: ID_EX_FORWARD_EN (forwarding muxes; otherwise interlock on dependences).
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [CTRL_W-1:0]     id_alu_control,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [CTRL_W-1:0]     alu_control,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  hazard_stall
);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [DATA_W-1:0]     r_imm;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [CTRL_W-1:0]     r_alu_control;
    logic                  r_alu_src;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_mem_to_reg;

    logic                  w_ex_match;
    logic                  w_load_use;
    logic                  w_bubble;

    // EX destination against either ID source; register 0 is never a real dependence.
    assign w_ex_match = (r_write_reg != '0) &&
                        ((r_write_reg == id_rs) || (r_write_reg == id_rt));
    assign w_load_use = id_valid && r_valid && r_mem_read && w_ex_match;

`ifdef ID_EX_FORWARD_EN
    assign hazard_stall = w_load_use;
`else
    logic w_ex_dep;
    logic w_mem_dep;

    // Without forwarding any in-flight producer of an ID source must drain first.
    assign w_ex_dep  = id_valid && r_valid && r_reg_write && w_ex_match;
    assign w_mem_dep = id_valid && exmem_reg_write &&
                       (((id_rs != '0) && (id_rs == exmem_rd)) ||
                        ((id_rt != '0) && (id_rt == exmem_rd)));
    assign hazard_stall = w_load_use || w_ex_dep || w_mem_dep;
`endif

    // Flush kills even while frozen; a hazard bubble only happens when not frozen.
    assign w_bubble = flush || (!stall && hazard_stall);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_write_reg   <= '0;
            r_alu_control <= '0;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            r_valid       <= id_valid;
            r_rs_data     <= id_rs_data;
            r_rt_data     <= id_rt_data;
            r_imm         <= id_imm;
            r_rs          <= id_rs;
            r_rt          <= id_rt;
            r_write_reg   <= id_reg_dst ? id_rd : id_rt;
            r_alu_control <= id_alu_control;
            r_alu_src     <= id_alu_src;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
            r_mem_write   <= id_mem_write;
            r_mem_to_reg  <= id_mem_to_reg;
        end
    end

    // Operand 0 is rs (ALU A), operand 1 is rt (ALU B / store data).
    logic [REG_ADDR_W-1:0] w_src     [2];
    logic [DATA_W-1:0]     w_reg_val [2];
    logic [DATA_W-1:0]     w_fwd_val [2];

    assign w_src[0]     = r_rs;
    assign w_src[1]     = r_rt;
    assign w_reg_val[0] = r_rs_data;
    assign w_reg_val[1] = r_rt_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef ID_EX_FORWARD_EN
            logic w_hit_exmem;
            logic w_hit_memwb;
            assign w_hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == w_src[gi]);
            assign w_hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == w_src[gi]);
            // The younger result (EX/MEM) takes precedence.
            assign w_fwd_val[gi] = w_hit_exmem ? exmem_result :
                                   w_hit_memwb ? memwb_result : w_reg_val[gi];
`else
            assign w_fwd_val[gi] = w_reg_val[gi];
`endif
        end
    endgenerate

`ifndef ID_EX_FORWARD_EN
    logic w_unused;
    assign w_unused = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                        w_src[0], w_src[1]};
`endif

    assign ex_valid      = r_valid;
    assign alu_a         = w_fwd_val[0];
    assign alu_b         = r_alu_src ? r_imm : w_fwd_val[1];
    assign ex_store_data = w_fwd_val[1];
    assign alu_control   = r_alu_control;
    assign ex_write_reg  = r_write_reg;
    assign ex_reg_write  = r_reg_write  & r_valid;
    assign ex_mem_read   = r_mem_read   & r_valid;
    assign ex_mem_write  = r_mem_write  & r_valid;
    assign ex_mem_to_reg = r_mem_to_reg & r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding checks follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_stall;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_write_reg;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_control(id_alu_control),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .hazard_stall(hazard_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t v=%0b a=%h b=%h ctl=%h wr=%0d rw=%0b mr=%0b hz=%0b",
                 $time, ex_valid, alu_a, alu_b, alu_control, ex_write_reg,
                 ex_reg_write, ex_mem_read, hazard_stall);
    endtask

    task automatic clear_id();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_control = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 1'($urandom); flush = 1'($urandom); id_valid = 1;
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_alu_control = 4'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1;
        exmem_reg_write = 0; exmem_rd = 5'($urandom); exmem_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom); memwb_result = $urandom;
        tick(); tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
        n_cmp++; if (alu_control !== 4'h0) begin n_fail++; $display("FAIL reset_ctl got %h want 0", alu_control); end
        n_cmp++; if (ex_write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_wreg got %0d want 0", ex_write_reg); end
        n_cmp++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 4'b0)
            begin n_fail++; $display("FAIL reset_ctrlbits got %b want 0000", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %0b want 0", hazard_stall); end
`ifndef ID_EX_FORWARD_EN
        n_cmp++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL reset_alu_a got %h want 0", alu_a); end
        n_cmp++; if (ex_store_data !== 32'h0) begin n_fail++; $display("FAIL reset_store got %h want 0", ex_store_data); end
`endif
        reset = 0;
        clear_id();
        tick();
    endtask

    task automatic test_capture();
        id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 9; id_reg_dst = 1;
        id_rs_data = 5; id_rt_data = 7; id_alu_src = 0; id_alu_control = 4'b0010; id_reg_write = 1;
        tick();
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0b want 1", ex_valid); end
        n_cmp++; if (alu_a !== 32'd5) begin n_fail++; $display("FAIL add_alu_a got %h want 5", alu_a); end
        n_cmp++; if (alu_b !== 32'd7) begin n_fail++; $display("FAIL add_alu_b got %h want 7", alu_b); end
        n_cmp++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL add_ctl got %h want 2", alu_control); end
        n_cmp++; if (ex_write_reg !== 5'd9) begin n_fail++; $display("FAIL add_wreg got %0d want 9", ex_write_reg); end
        n_cmp++; if (ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL add_rw got %0b want 1", ex_reg_write); end
        // Immediate form with rt as destination.
        id_alu_src = 1; id_imm = 32'h10; id_rt_data = 32'h77; id_reg_dst = 0; id_alu_control = 4'b0111;
        tick();
        n_cmp++; if (alu_b !== 32'h10) begin n_fail++; $display("FAIL imm_alu_b got %h want 10", alu_b); end
        n_cmp++; if (ex_store_data !== 32'h77) begin n_fail++; $display("FAIL imm_store got %h want 77", ex_store_data); end
        n_cmp++; if (ex_write_reg !== 5'd2) begin n_fail++; $display("FAIL imm_wreg got %0d want 2", ex_write_reg); end
        n_cmp++; if (alu_control !== 4'b0111) begin n_fail++; $display("FAIL imm_ctl got %h want 7", alu_control); end
    endtask

    task automatic test_load_use();
        clear_id();
        id_valid = 1; id_rs = 1; id_rt = 4; id_reg_dst = 0;
        id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_alu_src = 1; id_alu_control = 4'b0010;
        #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lw_pre_hazard got %0b want 0", hazard_stall); end
        tick();
        n_cmp++; if (ex_mem_read !== 1'b1 || ex_write_reg !== 5'd4)
            begin n_fail++; $display("FAIL lw_capture got mr=%0b wreg=%0d want mr=1 wreg=4", ex_mem_read, ex_write_reg); end
        id_mem_read = 0; id_mem_to_reg = 0; id_alu_src = 0; id_reg_dst = 1; id_rd = 5; id_rt = 4;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_hazard got %0b want 1", hazard_stall); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0)
            begin n_fail++; $display("FAIL lu_bubble got v=%0b rw=%0b mr=%0b want 000", ex_valid, ex_reg_write, ex_mem_read); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %0b want 0", hazard_stall); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_write_reg !== 5'd5)
            begin n_fail++; $display("FAIL lu_resume got v=%0b wreg=%0d want v=1 wreg=5", ex_valid, ex_write_reg); end
    endtask

    task automatic test_stall_flush();
        clear_id();
        id_valid = 1; id_rs_data = 32'h11; id_rt_data = 32'h22; id_alu_control = 4'b0001;
        id_reg_write = 1; id_reg_dst = 1; id_rd = 7;
        tick();
        n_cmp++; if (alu_a !== 32'h11) begin n_fail++; $display("FAIL st_capture got %h want 11", alu_a); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs_data = 32'h100 + i; id_rt_data = 32'h200 + i; id_alu_control = 4'b0110;
            id_rd = 5'(10 + i); id_valid = 1'(i);
            tick();
            n_cmp++; if (alu_a !== 32'h11 || alu_b !== 32'h22 || alu_control !== 4'b0001 ||
                         ex_valid !== 1'b1 || ex_write_reg !== 5'd7)
                begin n_fail++; $display("FAIL stall_hold%0d got a=%h b=%h ctl=%h v=%0b wreg=%0d want 11 22 1 1 7",
                                         i, alu_a, alu_b, alu_control, ex_valid, ex_write_reg); end
        end
        flush = 1;
        tick();
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0)
            begin n_fail++; $display("FAIL stall_flush got v=%0b rw=%0b want 00", ex_valid, ex_reg_write); end
        flush = 0; stall = 0; id_valid = 1; id_rd = 7;
        tick();
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL refill got %0b want 1", ex_valid); end
        stall = 1; reset = 1;
        tick();
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0)
            begin n_fail++; $display("FAIL reset_in_stall got v=%0b rw=%0b want 00", ex_valid, ex_reg_write); end
        reset = 0; stall = 0;
        // Flush coinciding with a load-use hazard yields one bubble only.
        clear_id();
        id_valid = 1; id_rt = 4; id_mem_read = 1; id_reg_write = 1;
        tick();
        id_mem_read = 0; id_reg_dst = 1; id_rd = 8; flush = 1;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL fh_hazard got %0b want 1", hazard_stall); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL fh_bubble got %0b want 0", ex_valid); end
        flush = 0;
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_write_reg !== 5'd8)
            begin n_fail++; $display("FAIL fh_single got v=%0b wreg=%0d want 1 8", ex_valid, ex_write_reg); end
    endtask

`ifdef ID_EX_FORWARD_EN
    task automatic test_forward();
        clear_id(); reset = 1; tick(); reset = 0;
        id_valid = 1; id_rs = 3; id_rt = 8; id_rs_data = 32'h33; id_rt_data = 32'h88;
        tick();
        clear_id();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
        #1;
        n_cmp++; if (alu_a !== 32'hAA) begin n_fail++; $display("FAIL fwd_exmem got %h want aa", alu_a); end
        exmem_reg_write = 0;
        #1;
        n_cmp++; if (alu_a !== 32'hBB) begin n_fail++; $display("FAIL fwd_memwb got %h want bb", alu_a); end
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h55; memwb_reg_write = 0;
        #1;
        n_cmp++; if (alu_a !== 32'h33) begin n_fail++; $display("FAIL fwd_r0 got %h want 33", alu_a); end
        exmem_rd = 8; exmem_result = 32'hCC;
        #1;
        n_cmp++; if (alu_b !== 32'hCC || ex_store_data !== 32'hCC)
            begin n_fail++; $display("FAIL fwd_rt got b=%h sd=%h want cc cc", alu_b, ex_store_data); end
        id_valid = 1; id_rs = 8;
        #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_nohazard got %0b want 0", hazard_stall); end
        clear_id();
    endtask
`else
    task automatic test_interlock();
        clear_id(); reset = 1; tick(); reset = 0;
        id_valid = 1; id_rs = 3; id_rs_data = 32'h33; id_reg_write = 1; id_reg_dst = 1; id_rd = 6;
        tick();
        clear_id();
        id_valid = 1; exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
        #1;
        n_cmp++; if (alu_a !== 32'h33) begin n_fail++; $display("FAIL nofwd_alu_a got %h want 33", alu_a); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL nofwd_r0 got %0b want 0", hazard_stall); end
        id_rs = 3;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL nofwd_exmem got %0b want 1", hazard_stall); end
        exmem_reg_write = 0;
        #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL nofwd_clear got %0b want 0", hazard_stall); end
        id_rt = 6;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL nofwd_exdest got %0b want 1", hazard_stall); end
        id_valid = 0;
        #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL nofwd_invalid got %0b want 0", hazard_stall); end
        clear_id();
    endtask
`endif

    initial begin
        clear_id();
        reset = 1;
        test_reset();
        test_capture();
        test_load_use();
        test_stall_flush();
`ifdef ID_EX_FORWARD_EN
        test_forward();
`else
        test_interlock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
